cpu_axil_master: RTL and testbench

Bridge from the CPU's native valid/ready memory port to a single AXI4-Lite master, placed directly upstream of the AXI-Lite BRAM memory and interconnect slaves. It accepts one CPU request at a time and drives AW+W+B for stores or AR+R for loads and fetches. It returns read data and a one-cycle `mem_ready` pulse. Responses other than OKAY are flagged to the CPU.

---
 rtl/axil_pkg.sv | 32 +++
 rtl/axil_watchdog.sv | 28 ++
 rtl/cpu_axil_master.sv | 170 +++++++++++++++++
 tb/tb_cpu_axil_master.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite types and constants for the CPU bridge.
// Holds response codes, bridge FSM states and protection encodings.
package axil_pkg;

  typedef enum logic [1:0] {
    AXIL_OKAY   = 2'b00,
    AXIL_EXOKAY = 2'b01,
    AXIL_SLVERR = 2'b10,
    AXIL_DECERR = 2'b11
  } axil_resp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR_DATA,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_DONE
  } cpu_axil_state_t;

  localparam logic [2:0] AXIL_PROT_INSTR = 3'b100;
  localparam logic [2:0] AXIL_PROT_DATA  = 3'b000;

  localparam logic [31:0] AXIL_TIMEOUT_DATA = 32'hDEADBEEF;

  function automatic logic resp_is_err(
    input logic [1:0] resp
  );
    return resp != 2'(AXIL_OKAY);
  endfunction

endpackage

// File: rtl/axil_watchdog.sv
// Cycle watchdog: counts enabled cycles, reports when LIMIT is hit.
// Ports: aclk, areset (sync, high), clear, enable -> expired.
module axil_watchdog #(
  parameter int LIMIT = 1024
) (
  input  logic aclk,
  input  logic areset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  // expired on the LIMIT-th enabled cycle
  assign expired = enable && (cnt == CW'(LIMIT - 1));

  always_ff @(posedge aclk) begin
    if (areset || clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/cpu_axil_master.sv
// CPU valid/ready port to single AXI4-Lite master, one request at a time.
// Ports: aclk, areset (sync, high), mem_* CPU side, m_axil_* AXI side.
// CPU_AXIL_MASTER_TIMEOUT_EN adds a watchdog (TIMEOUT_CYCLES) that
// completes a hung request with mem_err=1 and rdata 0xDEADBEEF.
module cpu_axil_master
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  mem_valid,
  input  logic                  mem_instr,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [STRB_WIDTH-1:0] mem_wstrb,
  output logic                  mem_ready,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_err,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  cpu_axil_state_t state;

  logic wd_expired;
  logic aw_ok;
  logic w_ok;

  // a channel is finished once its valid is gone or is handshaking now
  assign aw_ok = !m_axil_awvalid || m_axil_awready;
  assign w_ok  = !m_axil_wvalid  || m_axil_wready;

`ifdef CPU_AXIL_MASTER_TIMEOUT_EN
  logic wd_busy;
  logic wd_clear;

  assign wd_busy  = (state != ST_IDLE) && (state != ST_DONE);
  assign wd_clear = (state == ST_IDLE);

  axil_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .aclk   (aclk),
    .areset (areset),
    .clear  (wd_clear),
    .enable (wd_busy),
    .expired(wd_expired)
  );
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign wd_expired     = 1'b0;
`endif

  always_ff @(posedge aclk) begin
    if (areset) begin
      state          <= ST_IDLE;
      mem_ready      <= 1'b0;
      mem_err        <= 1'b0;
      mem_rdata      <= '0;
      m_axil_awaddr  <= '0;
      m_axil_awprot  <= AXIL_PROT_DATA;
      m_axil_awvalid <= 1'b0;
      m_axil_wdata   <= '0;
      m_axil_wstrb   <= '0;
      m_axil_wvalid  <= 1'b0;
      m_axil_bready  <= 1'b0;
      m_axil_araddr  <= '0;
      m_axil_arprot  <= AXIL_PROT_DATA;
      m_axil_arvalid <= 1'b0;
      m_axil_rready  <= 1'b0;
    end else if (wd_expired) begin
      state          <= ST_DONE;
      m_axil_awvalid <= 1'b0;
      m_axil_wvalid  <= 1'b0;
      m_axil_bready  <= 1'b0;
      m_axil_arvalid <= 1'b0;
      m_axil_rready  <= 1'b0;
      mem_ready      <= 1'b1;
      mem_err        <= 1'b1;
      mem_rdata      <= DATA_WIDTH'(AXIL_TIMEOUT_DATA);
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (mem_valid) begin
            if (mem_wstrb != '0) begin
              m_axil_awaddr  <= mem_addr;
              m_axil_awprot  <= AXIL_PROT_DATA;
              m_axil_wdata   <= mem_wdata;
              m_axil_wstrb   <= mem_wstrb;
              m_axil_awvalid <= 1'b1;
              m_axil_wvalid  <= 1'b1;
              state          <= ST_WR_ADDR_DATA;
            end else begin
              m_axil_araddr  <= mem_addr;
              m_axil_arprot  <= mem_instr ? AXIL_PROT_INSTR
                                          : AXIL_PROT_DATA;
              m_axil_arvalid <= 1'b1;
              state          <= ST_RD_ADDR;
            end
          end
        end
        ST_WR_ADDR_DATA: begin
          if (m_axil_awready) m_axil_awvalid <= 1'b0;
          if (m_axil_wready)  m_axil_wvalid  <= 1'b0;
          if (aw_ok && w_ok) begin
            m_axil_bready <= 1'b1;
            state         <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (m_axil_bvalid) begin
            m_axil_bready <= 1'b0;
            mem_err       <= resp_is_err(m_axil_bresp);
            mem_rdata     <= '0;
            mem_ready     <= 1'b1;
            state         <= ST_DONE;
          end
        end
        ST_RD_ADDR: begin
          if (m_axil_arready) begin
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b1;
            state          <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (m_axil_rvalid) begin
            m_axil_rready <= 1'b0;
            mem_rdata     <= m_axil_rdata;
            mem_err       <= resp_is_err(m_axil_rresp);
            mem_ready     <= 1'b1;
            state         <= ST_DONE;
          end
        end
        ST_DONE: begin
          // mem_valid is not looked at here: no reissue of the request
          mem_ready <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_axil_master.sv
// Self-checking bench for cpu_axil_master: random requests against a
// behavioural AXI-Lite slave and a transaction-level memory model.
module tb_cpu_axil_master;
  import axil_pkg::*;

  localparam int TO = 16;

  logic        aclk = 1'b0;
  logic        areset;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  always #5 aclk = ~aclk;

  cpu_axil_master #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .STRB_WIDTH    (4),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .mem_valid     (mem_valid),
    .mem_instr     (mem_instr),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata),
    .mem_err       (mem_err),
    .m_axil_awaddr (awaddr),
    .m_axil_awprot (awprot),
    .m_axil_awvalid(awvalid),
    .m_axil_awready(awready),
    .m_axil_wdata  (wdata),
    .m_axil_wstrb  (wstrb),
    .m_axil_wvalid (wvalid),
    .m_axil_wready (wready),
    .m_axil_bresp  (bresp),
    .m_axil_bvalid (bvalid),
    .m_axil_bready (bready),
    .m_axil_araddr (araddr),
    .m_axil_arprot (arprot),
    .m_axil_arvalid(arvalid),
    .m_axil_arready(arready),
    .m_axil_rdata  (rdata),
    .m_axil_rresp  (rresp),
    .m_axil_rvalid (rvalid),
    .m_axil_rready (rready)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // slave configuration, written by the stimulus process only
  int         aw_dly = 0;
  int         w_dly  = 0;
  int         b_dly  = 0;
  int         ar_dly = 0;
  int         r_dly  = 0;
  logic [1:0] s_resp = 2'b00;
  bit         spur   = 1'b0;

  // slave state, written by the slave process only
  logic [31:0] smem [16];
  int          n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
  int          av_cyc = 0, wv_cyc = 0;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  logic [3:0]  cap_wstrb;
  logic [2:0]  cap_awprot, cap_arprot;

  // reference memory, updated per completed transaction
  logic [31:0] ref_mem [16];

  initial begin : slave
    int  aw_ctr, w_ctr, b_ctr, ar_ctr, r_ctr;
    bit  aw_got, w_got, b_pend, r_pend, r_real;
    bit  b_fire, r_fire;
    aw_ctr = 0; w_ctr = 0; b_ctr = 0; ar_ctr = 0; r_ctr = 0;
    aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; r_real = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    forever begin
      @(posedge aclk);
      b_fire = bvalid && bready;
      r_fire = rvalid && rready;
      if (!areset) begin
        if (awvalid) av_cyc++;
        if (wvalid)  wv_cyc++;
        if (awvalid && awready) begin
          n_aw++;
          cap_awaddr = awaddr;
          cap_awprot = awprot;
          aw_got     = 1;
        end
        if (wvalid && wready) begin
          n_w++;
          cap_wdata = wdata;
          cap_wstrb = wstrb;
          w_got     = 1;
        end
        if (b_fire) n_b++;
        if (arvalid && arready) begin
          n_ar++;
          cap_araddr = araddr;
          cap_arprot = arprot;
          r_pend     = 1;
          r_ctr      = 0;
        end
        if (r_fire) n_r++;
      end
      #1;
      if (areset) begin
        aw_ctr = 0; w_ctr = 0; ar_ctr = 0;
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; r_real = 0;
        awready = 0; wready = 0; bvalid = 0;
        arready = 0; rvalid = 0;
      end else begin
        if (awvalid) begin
          awready = (aw_ctr >= aw_dly);
          if (!awready) aw_ctr++;
        end else begin
          awready = 0; aw_ctr = 0;
        end
        if (wvalid) begin
          wready = (w_ctr >= w_dly);
          if (!wready) w_ctr++;
        end else begin
          wready = 0; w_ctr = 0;
        end
        if (b_fire) bvalid = 0;
        if (aw_got && w_got) begin
          aw_got = 0; w_got = 0; b_pend = 1; b_ctr = 0;
        end
        if (b_pend) begin
          if (b_ctr >= b_dly) begin
            b_pend = 0;
            bvalid = 1;
            bresp  = s_resp;
            if (s_resp == 2'b00) begin
              for (int b = 0; b < 4; b++)
                if (cap_wstrb[b])
                  smem[cap_awaddr[5:2]][b*8 +: 8] = cap_wdata[b*8 +: 8];
            end
          end else begin
            b_ctr++;
          end
        end
        if (arvalid) begin
          arready = (ar_ctr >= ar_dly);
          if (!arready) ar_ctr++;
        end else begin
          arready = 0; ar_ctr = 0;
        end
        if (r_fire) begin
          rvalid = 0; r_real = 0;
        end
        if (!r_real) begin
          // junk beat presented while the address is still pending
          rvalid = spur && arvalid && !arready;
          rdata  = 32'hBAD0BAD0;
          rresp  = 2'b10;
        end
        if (r_pend) begin
          if (r_ctr >= r_dly) begin
            r_pend = 0;
            r_real = 1;
            rvalid = 1;
            rdata  = smem[cap_araddr[5:2]];
            rresp  = s_resp;
          end else begin
            r_ctr++;
          end
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_ctl"},
          {27'b0, awvalid, wvalid, bready, arvalid, rready}, 0);
    check({tag, "_ready"}, {31'b0, mem_ready}, 0);
    check({tag, "_err"}, {31'b0, mem_err}, 0);
    check({tag, "_rdata"}, mem_rdata, 0);
    check({tag, "_awaddr"}, awaddr, 0);
    check({tag, "_araddr"}, araddr, 0);
    check({tag, "_wdata"}, wdata, 0);
    check({tag, "_wstrb"}, {28'b0, wstrb}, 0);
  endtask

  task automatic xact(input logic [31:0] a,
                      input logic [31:0] d,
                      input logic [3:0]  s,
                      input logic        ins);
    int          lat, exp_lat, idx;
    int          k_aw, k_w, k_b, k_ar, k_r, k_av, k_wv;
    bit          seen, wr;
    logic [31:0] exp_rd;
    wr      = (s != 4'b0);
    idx     = int'(a[5:2]);
    exp_lat = wr ? 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly
                 : 3 + ar_dly + r_dly;
    exp_rd  = wr ? 32'h0 : ref_mem[idx];
    k_aw = n_aw; k_w = n_w; k_b = n_b; k_ar = n_ar; k_r = n_r;
    k_av = av_cyc; k_wv = wv_cyc;
    @(negedge aclk);
    mem_valid = 1; mem_addr = a; mem_wdata = d;
    mem_wstrb = s; mem_instr = ins;
    lat = 0; seen = 0;
    while (!seen && lat < 300) begin
      @(negedge aclk);
      lat++;
      if (mem_ready) seen = 1;
    end
    mem_valid = 0;
    check("ready_seen", {31'b0, seen}, 1);
    if (seen) begin
      check("latency", lat, exp_lat);
      check("rdata", mem_rdata, exp_rd);
      check("err", {31'b0, mem_err}, {31'b0, s_resp != 2'b00});
    end
    @(negedge aclk);
    check("ready_pulse", {31'b0, mem_ready}, 0);
    if (wr) begin
      check("n_aw", n_aw - k_aw, 1);
      check("n_w", n_w - k_w, 1);
      check("n_b", n_b - k_b, 1);
      check("n_ar_on_wr", n_ar - k_ar, 0);
      check("awvalid_cyc", av_cyc - k_av, aw_dly + 1);
      check("wvalid_cyc", wv_cyc - k_wv, w_dly + 1);
      check("awaddr", cap_awaddr, a);
      check("awprot", {29'b0, cap_awprot}, 0);
      check("wdata", cap_wdata, d);
      check("wstrb", {28'b0, cap_wstrb}, {28'b0, s});
      if (s_resp == 2'b00) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) ref_mem[idx][b*8 +: 8] = d[b*8 +: 8];
      end
    end else begin
      check("n_ar", n_ar - k_ar, 1);
      check("n_r", n_r - k_r, 1);
      check("n_aw_on_rd", n_aw - k_aw, 0);
      check("araddr", cap_araddr, a);
      check("arprot", {29'b0, cap_arprot}, {29'b0, ins, 2'b00});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    int  cnt;
    bit  hit;
    logic [31:0] a, d;
    logic [3:0]  s;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      smem[i]    = d;
      ref_mem[i] = d;
    end
    smem[4]    = 32'h12345678;
    ref_mem[4] = 32'h12345678;
    areset = 1; mem_valid = 0; mem_instr = 0;
    mem_addr = 0; mem_wdata = 0; mem_wstrb = 0;
    repeat (3) @(negedge aclk);
    check_zero("reset");
    areset = 0;
    @(negedge aclk);

    xact(32'h10, 32'h0, 4'b0, 1'b0);
    xact(32'h0, 32'h0, 4'b0, 1'b1);

    aw_dly = 2;
    xact(32'h20, 32'hAABBCCDD, 4'b0011, 1'b0);
    aw_dly = 0;
    xact(32'h20, 32'h0, 4'b0, 1'b0);

    s_resp = 2'b10;
    xact(32'h24, 32'h0, 4'b0, 1'b0);
    s_resp = 2'b00;

    spur = 1; ar_dly = 3;
    xact(32'h8, 32'h0, 4'b0, 1'b0);
    spur = 0; ar_dly = 0;

    // reset while waiting for the write response
    b_dly = 50;
    @(negedge aclk);
    mem_valid = 1; mem_addr = 32'h30;
    mem_wdata = 32'h01020304; mem_wstrb = 4'hF;
    cnt = 0; hit = 0;
    while (!bready && cnt < 20) begin
      @(negedge aclk);
      cnt++;
      if (mem_ready) hit = 1;
    end
    check("wr_resp_reached", {31'b0, bready}, 1);
    areset = 1; mem_valid = 0; mem_wstrb = 0;
    repeat (3) begin
      @(negedge aclk);
      if (mem_ready) hit = 1;
    end
    check("no_ready_on_reset", {31'b0, hit}, 0);
    check_zero("midreset");
    areset = 0; b_dly = 0;
    @(negedge aclk);
    xact(32'h30, 32'h0, 4'b0, 1'b0);

`ifdef CPU_AXIL_MASTER_TIMEOUT_EN
    begin : timeout_case
      int k_ar;
      ar_dly = 100000;
      k_ar = n_ar;
      @(negedge aclk);
      mem_valid = 1; mem_addr = 32'h14;
      mem_wstrb = 4'b0; mem_instr = 0;
      cnt = 0; hit = 0;
      while (!hit && cnt < 100) begin
        @(negedge aclk);
        cnt++;
        if (mem_ready) hit = 1;
      end
      mem_valid = 0;
      check("to_seen", {31'b0, hit}, 1);
      check("to_latency", cnt, TO + 1);
      check("to_rdata", mem_rdata, 32'hDEADBEEF);
      check("to_err", {31'b0, mem_err}, 1);
      check("to_arvalid", {31'b0, arvalid}, 0);
      check("to_no_ar", n_ar - k_ar, 0);
      ar_dly = 0;
      @(negedge aclk);
    end
`endif

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
      end else begin
        aw_dly = $urandom_range(0, 3);
        w_dly  = $urandom_range(0, 3);
        b_dly  = $urandom_range(0, 3);
        ar_dly = $urandom_range(0, 3);
        r_dly  = $urandom_range(0, 3);
      end
      s_resp = ($urandom_range(0, 3) != 0) ? 2'b00
                                           : 2'($urandom_range(1, 3));
      a = $urandom;
      d = $urandom;
      s = ($urandom_range(0, 1) == 0) ? 4'b0
                                      : 4'($urandom_range(1, 15));
      xact(a, d, s, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
